// File: rtl/cfg_frame_loader.sv
// Configuration frame loader: collects a byte-serial frame (sync, payload,
// checksum) into a shadow register and commits it to the fabric select vector
// in a single edge, so the routing blocks never see a partial configuration.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_SYNC | hunting for the sync byte; any other byte is dropped
// S_DATA | collecting payload bytes into the shadow, accumulating sum
// S_CSUM | waiting for the checksum byte; commit or flag an error
// S_HOLD | one cycle after a commit with the input port closed
module cfg_frame_loader #(
   parameter int         CFG_WIDTH = 900,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 abort,
   output logic [CFG_WIDTH-1:0] cfg_out,
   output logic                 cfg_loaded,
   output logic                 busy,
   output logic                 done,
   output logic                 csum_err
);

   localparam int         NBYTES   = (CFG_WIDTH + 7) / 8;
   localparam logic [6:0] LAST_IDX = 7'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_SYNC = 2'd0,
      S_DATA = 2'd1,
      S_CSUM = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 started;
   logic [6:0]           cnt;
   logic [7:0]           sum;
   logic [CFG_WIDTH-1:0] shadow;
   logic                 csum_err_q;
   logic                 xfer;
   logic                 sync_hit;
   logic                 csum_ok;

   assign xfer     = in_valid && in_ready;
   assign sync_hit = (in_data == SYNC_BYTE);
   assign csum_ok  = (in_data == sum);

   // State register; reset returns the FSM to sync hunting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides any byte transfer in the same cycle.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_SYNC;
      end else begin
         case (state)
            S_SYNC: if (xfer && sync_hit) state_nxt = S_DATA;
            S_DATA: if (xfer && (cnt == LAST_IDX)) state_nxt = S_CSUM;
            S_CSUM: if (xfer) state_nxt = csum_ok ? S_HOLD : S_SYNC;
            S_HOLD: state_nxt = S_SYNC;
            default: state_nxt = S_SYNC;
         endcase
      end
   end

   // Output decode; done coincides with the S_HOLD cycle that follows a commit.
   always_comb begin
      in_ready = started && (state != S_HOLD);
      busy     = (state == S_DATA) || (state == S_CSUM);
      done     = (state == S_HOLD);
      csum_err = csum_err_q;
   end

   // Port opens on the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
      end else begin
         started <= 1'b1;
      end
   end

   // Frame datapath: byte counter, running checksum and shadow assembly.
   // The last byte only has CFG_WIDTH%8 bits mapped; its upper bits fall
   // outside the shadow but still feed the checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         sum    <= '0;
         shadow <= '0;
      end else if (abort) begin
         cnt    <= '0;
         sum    <= '0;
         shadow <= '0;
      end else if (xfer) begin
         if (state == S_SYNC && sync_hit) begin
            cnt    <= '0;
            sum    <= '0;
            shadow <= '0;
         end else if (state == S_DATA) begin
            for (int k = 0; k < CFG_WIDTH; k++) begin
               if (cnt == 7'(k / 8)) shadow[k] <= in_data[k % 8];
            end
            sum <= sum + in_data;
            if (cnt != LAST_IDX) cnt <= cnt + 7'd1;
         end
      end
   end

   // Commit path: the active vector only ever changes on a good checksum or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_out    <= '0;
         cfg_loaded <= 1'b0;
         csum_err_q <= 1'b0;
      end else begin
         csum_err_q <= 1'b0;
         if (!abort && xfer && state == S_CSUM) begin
            if (csum_ok) begin
               cfg_out    <= shadow;
               cfg_loaded <= 1'b1;
            end else begin
               csum_err_q <= 1'b1;
            end
         end
      end
   end

endmodule
